cell4_bist: RTL and testbench
=============================

# cell4_bist

Built-in self-test controller for the four-input gate cells of the library, such as the OAI22 function `Y = ~((A1|A2)&(B1|B2))`.
- The block drives the cell inputs A1, A2, B1 and B2, and samples the cell output back on Y_IN.
- It sweeps all 16 input patterns and compares each sampled Y_IN against an internal OAI22 model.
- It compacts the sampled responses into a MISR signature and reports pass/fail.
- It sits beside a cell instance in the benchmark harness: stimulus goes out to the cell, and the response comes back in.

## Interface
Parameters:
- SETTLE, default 2: cycles STIM is held before each sample; legal range is 1–15.
- NPASS, default 1: number of full 16-pattern sweeps per run; legal range is 1–15.
- SIG_W, default 16: width of the MISR signature.
- POLY, default 16'h100B: MISR feedback polynomial taps.
- SEED, default 16'h0000: value loaded into the MISR on START.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
  - CLK: input, 1 bit, rising-edge clock.
  - RN: input, 1 bit, asynchronous active-low reset.
- Run control:
  - START: input, 1 bit, starts a run when sampled high in IDLE.
  - ABORT: input, 1 bit, cancels a run.
- Cell stimulus (the current pattern P, with P[3]=A1, P[2]=A2, P[1]=B1, P[0]=B2):
  - A1: output, 1 bit, stimulus bit P[3].
  - A2: output, 1 bit, stimulus bit P[2].
  - B1: output, 1 bit, stimulus bit P[1].
  - B2: output, 1 bit, stimulus bit P[0].
- Cell response and golden input:
  - Y_IN: input, 1 bit, output of the cell under test.
  - EXP_SIG: input, SIG_W bits, golden signature; it must be stable while DONE is high.
- Status:
  - BUSY: output, 1 bit, high while a run is in progress.
  - DONE: output, 1 bit, high after a run completes; stays high until the next START.
  - PASS: output, 1 bit, valid while DONE is high.
  - ERR_CNT: output, 8 bits, count of mismatches; saturates at 255.
  - SIG: output, SIG_W bits, MISR signature.

## Operation
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - On START=1 (with ABORT=0): P<=0, SIG<=SEED, ERR_CNT<=0, settle counter<=0, pass counter<=0, DONE<=0, go to SETTLE.
- SETTLE:
  - Settle counter increments each cycle.
  - After SETTLE cycles in SETTLE, go to SAMPLE.
- SAMPLE (one cycle): Y_IN is captured.
  - Model check: exp = ~((P[3]|P[2])&(P[1]|P[0])). If Y_IN!=exp, ERR_CNT increments, saturating at 255.
  - MISR update: SIG <= {SIG[SIG_W-2:0],1'b0} ^ (SIG[SIG_W-1] ? POLY : 0) ^ {{SIG_W-1{1'b0}},Y_IN}.
  - If P=15 and this is the last pass: go to FINISH.
  - Otherwise: P<=P+1 (15 wraps to 0, and the pass counter increments), settle counter<=0, go to SETTLE.
  - The MISR is never reseeded between passes.
- FINISH:
  - DONE=1, BUSY=0.
  - PASS = (ERR_CNT==0) && (SIG==EXP_SIG), evaluated combinationally.
  - P holds 15, SIG holds its value, ERR_CNT holds its value.
  - START returns the block to IDLE-start behaviour, i.e. a new run begins on the same edge as in IDLE.
- ABORT:
  - ABORT=1 in SETTLE or SAMPLE: go to IDLE on the next edge with P<=0, DONE=0 and BUSY=0; SIG and ERR_CNT are frozen.
  - ABORT has priority over START.
  - ABORT in IDLE or FINISH has no effect.
- START while BUSY is ignored.
- BUSY=1 exactly in SETTLE and SAMPLE.
- Reset (RN=0, asynchronous, also mid-run):
  - State goes to IDLE.
  - A1, A2, B1, B2 = 0.
  - BUSY, DONE, PASS = 0.
  - ERR_CNT = 0.
  - SIG = 0.
  - Counters = 0.

## Timing
- Edge e0 is the edge that samples START.
  - Pattern n is driven from edge e0+n(SETTLE+1) and sampled at e0+(n+1)(SETTLE+1).
  - With the defaults, each pattern stays stable for 3 cycles before it is sampled.
- DONE rises after edge e0 + 16·NPASS·(SETTLE+1).
  - With defaults this is 48 cycles after START.
  - BUSY falls on the same edge that DONE rises.
- Y_IN must be stable from SETTLE cycles after the pattern changes until its SAMPLE edge. This covers the cell's propagation delay.
- All outputs are registered except PASS.

## Test plan
- Good OAI22 cell, defaults, SEED=0: START for 1 cycle -> BUSY high for 48 cycles, then DONE=1 and ERR_CNT=0.
  - The bench then sets EXP_SIG to the captured SIG and sees PASS=1.
  - A second run reproduces the same SIG.
- Y_IN stuck at 0, SEED=0 -> SIG=16'h0000 and ERR_CNT=7 (patterns 0,1,2,3,4,8,12), PASS=0.
- Y_IN stuck at 1 -> ERR_CNT=9 (patterns 5,6,7,9,10,11,13,14,15) and PASS=0.
- NPASS=2 with a good cell -> DONE after 96 cycles.
  - A1/A2/B1/B2 wrap from 15 to 0 once.
  - ERR_CNT=0.
- ABORT asserted at pattern 5 during SETTLE -> next edge: BUSY=0, DONE=0, stimulus=0, ERR_CNT frozen.
  - A following START gives a clean 48-cycle run.
  - START held high together with ABORT is ignored.
- RN pulsed low mid-run (pattern 9) -> all outputs are 0 immediately, without waiting for a clock.
  - After release, the block stays IDLE until START.
  - START pulses while BUSY do not restart the counters.

Source files
------------

// File: rtl/cell4_bist_if.sv
// Bus between the cell4 BIST controller and its harness.
// This bus carries run control, the cell stimulus and response, and status.
`timescale 1ns/1ps
interface cell4_bist_if #(parameter int SIG_W = 16);
  logic             START;
  logic             ABORT;
  logic             A1, A2, B1, B2;
  logic             Y_IN;
  logic [SIG_W-1:0] EXP_SIG;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [7:0]       ERR_CNT;
  logic [SIG_W-1:0] SIG;

  modport master (output START, ABORT, Y_IN, EXP_SIG,
                  input  A1, A2, B1, B2, BUSY, DONE, PASS, ERR_CNT, SIG);
  modport slave  (input  START, ABORT, Y_IN, EXP_SIG,
                  output A1, A2, B1, B2, BUSY, DONE, PASS, ERR_CNT, SIG);
endinterface

// File: rtl/cell4_bist.sv
// BIST controller for OAI22-style four-input cells.
// It sweeps 16 patterns per pass, checks each response against a model, and compacts the responses into a MISR.
`timescale 1ns/1ps
module cell4_bist #(
  parameter int             SETTLE = 2,
  parameter int             NPASS  = 1,
  parameter int             SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h100B,
  parameter logic [SIG_W-1:0] SEED = '0
) (
  input  logic        CLK,
  input  logic        RN,
  cell4_bist_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FINISH} state_t;

  localparam logic [3:0] SET_LAST  = 4'(SETTLE - 1);
  localparam logic [3:0] PASS_LAST = 4'(NPASS - 1);

  state_t           state, state_nxt;
  logic [3:0]       pat, set_cnt, pass_cnt;
  logic [7:0]       err_cnt;
  logic [SIG_W-1:0] sig, sig_nxt;
  logic             busy, done;
  logic             go, ab, last, exp_y;

  always_ff @(posedge CLK or negedge RN)
    if (!RN) state <= S_IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    ab        = 1'b0;
    last      = (pat == 4'hF) && (pass_cnt == PASS_LAST);
    case (state)
      S_IDLE, S_FINISH:
        if (bus.START && !bus.ABORT) begin
          go        = 1'b1;
          state_nxt = S_SETTLE;
        end
      S_SETTLE:
        if (bus.ABORT) begin
          ab        = 1'b1;
          state_nxt = S_IDLE;
        end else if (set_cnt == SET_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE:
        if (bus.ABORT) begin
          ab        = 1'b1;
          state_nxt = S_IDLE;
        end else state_nxt = last ? S_FINISH : S_SETTLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign exp_y   = ~((pat[3] | pat[2]) & (pat[1] | pat[0]));
  assign sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ {{(SIG_W-1){1'b0}}, bus.Y_IN};

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      pat      <= '0;
      set_cnt  <= '0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      sig      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE);
      done <= (state_nxt == S_FINISH);
      if (go) begin
        pat      <= '0;
        set_cnt  <= '0;
        pass_cnt <= '0;
        err_cnt  <= '0;
        sig      <= SEED;
      end else if (ab) begin
        // Abort parks the stimulus but keeps the partial signature and count visible.
        pat <= '0;
      end else if (state == S_SETTLE) begin
        set_cnt <= set_cnt + 4'd1;
      end else if (state == S_SAMPLE) begin
        sig <= sig_nxt;
        if (bus.Y_IN != exp_y && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (!last) begin
          pat     <= pat + 4'd1;
          set_cnt <= '0;
          if (pat == 4'hF) pass_cnt <= pass_cnt + 4'd1;
        end
      end
    end
  end

  assign {bus.A1, bus.A2, bus.B1, bus.B2} = pat;
  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign bus.ERR_CNT = err_cnt;
  assign bus.SIG     = sig;
  assign bus.PASS    = done && (err_cnt == 8'd0) && (sig == bus.EXP_SIG);
endmodule

// File: tb/tb_cell4_bist.sv
// Bench for cell4_bist: a default instance and an NPASS=2 instance, each driving a behavioural cell.
// Expected patterns and the final signature/count are queued at launch and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_cell4_bist;
  logic CLK = 1'b0;
  logic RN  = 1'b0;
  always #5 CLK = ~CLK;

  cell4_bist_if #(.SIG_W(16)) bus0 ();
  cell4_bist_if #(.SIG_W(16)) bus1 ();
  cell4_bist                dut0 (.CLK(CLK), .RN(RN), .bus(bus0));
  cell4_bist #(.NPASS(2))   dut1 (.CLK(CLK), .RN(RN), .bus(bus1));

  typedef struct { logic [15:0] sig; logic [7:0] err; } res_t;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  mode [2];
  logic [1:0]  start, abort;
  logic [15:0] exp_sig [2];
  logic [3:0]  pat [2];
  logic [1:0]  busy, done, pass;
  logic [7:0]  err [2];
  logic [15:0] sig [2];
  logic [3:0]  exp_q [$];
  res_t        res_q [$];
  logic [15:0] good_sig;

  function automatic logic oai(input logic [3:0] p);
    return ~((p[3] | p[2]) & (p[1] | p[0]));
  endfunction

  // mode 0: good cell, 1: stuck-at-0, 2: stuck-at-1
  function automatic logic cell_y(input logic [1:0] m, input logic [3:0] p);
    return (m == 2'd0) ? oai(p) : (m == 2'd1) ? 1'b0 : 1'b1;
  endfunction

  assign bus0.START = start[0];  assign bus1.START = start[1];
  assign bus0.ABORT = abort[0];  assign bus1.ABORT = abort[1];
  assign bus0.EXP_SIG = exp_sig[0];  assign bus1.EXP_SIG = exp_sig[1];
  assign pat[0] = {bus0.A1, bus0.A2, bus0.B1, bus0.B2};
  assign pat[1] = {bus1.A1, bus1.A2, bus1.B1, bus1.B2};
  assign bus0.Y_IN = cell_y(mode[0], pat[0]);
  assign bus1.Y_IN = cell_y(mode[1], pat[1]);
  assign busy = {bus1.BUSY, bus0.BUSY};
  assign done = {bus1.DONE, bus0.DONE};
  assign pass = {bus1.PASS, bus0.PASS};
  assign err[0] = bus0.ERR_CNT;  assign err[1] = bus1.ERR_CNT;
  assign sig[0] = bus0.SIG;      assign sig[1] = bus1.SIG;

  task automatic run(input int w, input logic [1:0] m, input int npass, input bit poke,
                     output logic [15:0] got_sig);
    logic [15:0] s = 16'h0000;
    int          e = 0;
    int          cyc = 0;
    int          prev = -1;
    int          hold = 0;
    logic        y;
    logic [3:0]  ep;
    res_t        r;
    mode[w] = m;
    exp_q.delete();
    for (int k = 0; k < npass; k++)
      for (int i = 0; i < 16; i++) begin
        exp_q.push_back(4'(i));
        y = cell_y(m, 4'(i));
        if (y != oai(4'(i))) e++;
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {15'b0, y};
      end
    res_q.push_back('{s, 8'(e)});
    @(posedge CLK); #1 start[w] = 1'b1;
    @(posedge CLK); #1 start[w] = 1'b0;
    while (!done[w] && cyc < 400) begin
      if (busy[w]) begin
        cyc++;
        if (int'(pat[w]) != prev) begin
          if (prev != -1) begin
            checks++;
            if (hold !== 3) begin
              errors++;
              $display("FAIL hold w=%0d pat=%0d: got %0d cycles, want 3", w, prev, hold);
            end
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pattern_extra w=%0d: got %0d, none expected", w, pat[w]);
          end else begin
            ep = exp_q.pop_front();
            if (pat[w] !== ep) begin
              errors++;
              $display("FAIL pattern w=%0d: got %0d, want %0d", w, pat[w], ep);
            end
          end
          prev = int'(pat[w]);
          hold = 1;
        end else hold++;
      end
      start[w] = poke && (cyc == 10);
      @(posedge CLK); #1;
    end
    start[w] = 1'b0;
    r = res_q.pop_front();
    checks++;
    if (done[w] !== 1'b1 || busy[w] !== 1'b0) begin
      errors++;
      $display("FAIL done w=%0d: got done=%b busy=%b, want 1/0", w, done[w], busy[w]);
    end
    checks++;
    if (cyc !== 48 * npass) begin
      errors++;
      $display("FAIL busy_cycles w=%0d: got %0d, want %0d", w, cyc, 48 * npass);
    end
    checks++;
    if (hold !== 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL last_pattern w=%0d: got hold=%0d left=%0d, want 3/0", w, hold, exp_q.size());
    end
    checks++;
    if (pat[w] !== 4'hF) begin
      errors++;
      $display("FAIL finish_pattern w=%0d: got %0d, want 15", w, pat[w]);
    end
    checks++;
    if (err[w] !== r.err) begin
      errors++;
      $display("FAIL err_cnt w=%0d: got %0d, want %0d", w, err[w], r.err);
    end
    checks++;
    if (sig[w] !== r.sig) begin
      errors++;
      $display("FAIL sig w=%0d: got %h, want %h", w, sig[w], r.sig);
    end
    got_sig = sig[w];
  endtask

  task automatic test_reset();
    #12;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (pat[w] !== 4'h0 || busy[w] !== 1'b0 || done[w] !== 1'b0 || pass[w] !== 1'b0 ||
          err[w] !== 8'h00 || sig[w] !== 16'h0000) begin
        errors++;
        $display("FAIL reset w=%0d: got pat=%h busy=%b done=%b pass=%b err=%0d sig=%h, want all 0",
                 w, pat[w], busy[w], done[w], pass[w], err[w], sig[w]);
      end
    end
    @(negedge CLK) RN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0/0", busy[0], done[0]);
    end
  endtask

  task automatic test_good();
    logic [15:0] s2;
    run(0, 2'd0, 1, 1'b0, good_sig);
    exp_sig[0] = good_sig;
    #1;
    checks++;
    if (pass[0] !== 1'b1) begin
      errors++;
      $display("FAIL pass_good: got %b, want 1", pass[0]);
    end
    exp_sig[0] = ~good_sig;
    #1;
    checks++;
    if (pass[0] !== 1'b0) begin
      errors++;
      $display("FAIL pass_wrong_sig: got %b, want 0", pass[0]);
    end
    exp_sig[0] = good_sig;
    run(0, 2'd0, 1, 1'b0, s2);
    checks++;
    if (s2 !== good_sig) begin
      errors++;
      $display("FAIL repeat_sig: got %h, want %h", s2, good_sig);
    end
  endtask

  task automatic test_stuck();
    logic [15:0] s;
    run(0, 2'd1, 1, 1'b0, s);
    checks++;
    if (err[0] !== 8'd7 || s !== 16'h0000 || pass[0] !== 1'b0) begin
      errors++;
      $display("FAIL stuck0: got err=%0d sig=%h pass=%b, want 7/0000/0", err[0], s, pass[0]);
    end
    run(0, 2'd2, 1, 1'b0, s);
    checks++;
    if (err[0] !== 8'd9 || pass[0] !== 1'b0) begin
      errors++;
      $display("FAIL stuck1: got err=%0d pass=%b, want 9/0", err[0], pass[0]);
    end
  endtask

  task automatic test_npass2();
    logic [15:0] s;
    run(1, 2'd0, 2, 1'b0, s);
    checks++;
    if (err[1] !== 8'd0) begin
      errors++;
      $display("FAIL npass2_err: got %0d, want 0", err[1]);
    end
  endtask

  task automatic test_abort();
    int          n = 0;
    logic [15:0] s;
    mode[0] = 2'd1;
    @(posedge CLK); #1 start[0] = 1'b1;
    @(posedge CLK); #1 start[0] = 1'b0;
    while (pat[0] != 4'd5 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (pat[0] !== 4'd5) begin
      errors++;
      $display("FAIL abort_reach: got pat=%0d, want 5", pat[0]);
    end
    abort[0] = 1'b1;
    start[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || pat[0] !== 4'd0 || err[0] !== 8'd5) begin
        errors++;
        $display("FAIL abort k=%0d: got busy=%b done=%b pat=%0d err=%0d, want 0/0/0/5",
                 k, busy[0], done[0], pat[0], err[0]);
      end
    end
    abort[0] = 1'b0;
    start[0] = 1'b0;
    run(0, 2'd0, 1, 1'b0, s);
    checks++;
    if (s !== good_sig) begin
      errors++;
      $display("FAIL after_abort_sig: got %h, want %h", s, good_sig);
    end
  endtask

  task automatic test_reset_mid();
    int          n = 0;
    logic [15:0] s;
    mode[0] = 2'd0;
    @(posedge CLK); #1 start[0] = 1'b1;
    @(posedge CLK); #1 start[0] = 1'b0;
    while (pat[0] != 4'd9 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    #2 RN = 1'b0;
    #1;
    checks++;
    if (pat[0] !== 4'h0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || pass[0] !== 1'b0 ||
        err[0] !== 8'h00 || sig[0] !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got pat=%h busy=%b done=%b pass=%b err=%0d sig=%h, want all 0",
               pat[0], busy[0], done[0], pass[0], err[0], sig[0]);
    end
    @(negedge CLK) RN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if (busy[0] !== 1'b0 || pat[0] !== 4'h0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL stay_idle: got busy=%b pat=%0d done=%b, want 0/0/0", busy[0], pat[0], done[0]);
    end
    run(0, 2'd0, 1, 1'b1, s);
    checks++;
    if (s !== good_sig) begin
      errors++;
      $display("FAIL busy_start_sig: got %h, want %h", s, good_sig);
    end
  endtask

  initial begin
    start = '0;
    abort = '0;
    mode[0] = 2'd0;  mode[1] = 2'd0;
    exp_sig[0] = '0; exp_sig[1] = '0;
    good_sig = '0;
    test_reset();
    test_good();
    test_stuck();
    test_npass2();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
